// File: rtl/log2_pkg.sv
// Shared types and constants for the log2 result BCD formatter.
package log2_pkg;

  localparam int INT_DIGITS  = 5;
  localparam int FRAC_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INT_CONV  = 2'd1,
    FRAC_CONV = 2'd2,
    DONE      = 2'd3
  } fmt_state_e;

  // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
  function automatic bcd_digit_t dabble_adjust(input bcd_digit_t d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/log2_bcd_fmt_if.sv
// Handshake and data bundle between the log2 unit side and the BCD formatter.
interface log2_bcd_fmt_if #(
  parameter int INT_W       = 16,
  parameter int FRAC_W      = 16,
  parameter int INT_DIGITS  = log2_pkg::INT_DIGITS,
  parameter int FRAC_DIGITS = log2_pkg::FRAC_DIGITS
);
  logic                     start_i;
  logic [INT_W-1:0]         Ynguyen_i;
  logic [FRAC_W-1:0]        Ythapphan_i;
  logic                     busy_o;
  logic                     done_o;
  logic [4*INT_DIGITS-1:0]  int_bcd_o;
  logic [4*FRAC_DIGITS-1:0] frac_bcd_o;

  modport master (
    output start_i, Ynguyen_i, Ythapphan_i,
    input  busy_o, done_o, int_bcd_o, frac_bcd_o
  );

  modport slave (
    input  start_i, Ynguyen_i, Ythapphan_i,
    output busy_o, done_o, int_bcd_o, frac_bcd_o
  );
endinterface

// File: rtl/log2_bcd_fmt_bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every nibble, then a 1-bit left shift.
module bcd_dabble_step
  import log2_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                shift_bit,
  output logic [4*DIGITS-1:0] bcd_next
);

  logic [4*DIGITS-1:0] adj;

  // Correct every nibble independently before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = dabble_adjust(bcd[4*i +: 4]);
    end
  end

  assign bcd_next = {adj[4*DIGITS-2:0], shift_bit};

endmodule

// File: rtl/log2_bcd_fmt.sv
// Converts the log2 integer/fraction results to packed BCD: double-dabble for the
// integer, repeated multiply-by-10 for the truncated fraction digits.
module log2_bcd_fmt
  import log2_pkg::*;
#(
  parameter int INT_W       = 16,
  parameter int FRAC_W      = 16,
  parameter int INT_DIGITS  = log2_pkg::INT_DIGITS,
  parameter int FRAC_DIGITS = log2_pkg::FRAC_DIGITS
) (
  input logic           clk_i,
  input logic           rst_i,
  log2_bcd_fmt_if.slave bus
);

  localparam int CNT_W = $clog2(INT_W + 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_W - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FRAC_DIGITS - 1);

  fmt_state_e               state_r;
  logic [INT_W-1:0]         shift_r;
  logic [FRAC_W-1:0]        acc_r;
  logic [4*INT_DIGITS-1:0]  int_work_r;
  logic [4*FRAC_DIGITS-1:0] frac_work_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     busy_r;
  logic                     done_r;
  logic [4*INT_DIGITS-1:0]  int_bcd_r;
  logic [4*FRAC_DIGITS-1:0] frac_bcd_r;

  logic [4*INT_DIGITS-1:0]  int_next_s;
  logic [FRAC_W+3:0]        acc_wide_s;
  logic [FRAC_W+3:0]        acc10_s;
  bcd_digit_t               frac_digit_s;

  bcd_dabble_step #(.DIGITS(INT_DIGITS)) u_dabble (
    .bcd       (int_work_r),
    .shift_bit (shift_r[INT_W-1]),
    .bcd_next  (int_next_s)
  );

  // acc*10 as 8*acc + 2*acc; the top nibble is the next decimal digit.
  assign acc_wide_s   = {4'd0, acc_r};
  assign acc10_s      = (acc_wide_s << 3) + (acc_wide_s << 1);
  assign frac_digit_s = acc10_s[FRAC_W+3:FRAC_W];

  // Conversion FSM; outputs change only on DONE or reset so they never show partial values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      acc_r       <= '0;
      int_work_r  <= '0;
      frac_work_r <= '0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      int_bcd_r   <= '0;
      frac_bcd_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            shift_r     <= bus.Ynguyen_i;
            acc_r       <= bus.Ythapphan_i;
            int_work_r  <= '0;
            frac_work_r <= '0;
            cnt_r       <= '0;
            busy_r      <= 1'b1;
            state_r     <= INT_CONV;
          end
        end
        INT_CONV: begin
          int_work_r <= int_next_s;
          shift_r    <= {shift_r[INT_W-2:0], 1'b0};
          if (cnt_r == INT_LAST) begin
            cnt_r   <= '0;
            state_r <= FRAC_CONV;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FRAC_CONV: begin
          acc_r       <= acc10_s[FRAC_W-1:0];
          frac_work_r <= {frac_work_r[4*FRAC_DIGITS-5:0], frac_digit_s};
          if (cnt_r == FRAC_LAST) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          int_bcd_r  <= int_work_r;
          frac_bcd_r <= frac_work_r;
          done_r     <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.int_bcd_o  = int_bcd_r;
  assign bus.frac_bcd_o = frac_bcd_r;

endmodule
